link_power_sequencer: RTL and testbench
=======================================

# link_power_sequencer

Downstream of the pair-check stage in the link-power path. Consumes the four per-pair good flags (12, 36, 54, 78), qualifies them with debounce and glitch timers, and sequences the power enables for the 1236 and 5478 pair groups. Handles fault counting, retry back-off and lockout. Runs on the 100 MHz clock produced by the crystal-doubling stage.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive good cycles required before enabling a group (10 µs).
- GLITCH_CYCLES, 16: consecutive bad cycles on a powered group that declare a fault.
- RETRY_CYCLES, 100000: back-off after a fault before returning to IDLE.
- FAULT_LIMIT, 3: fault count that forces LOCKOUT (1..7).

Ports:
- Clock100MhzP  in  1  sole clock.
- Reset  in  1  synchronous, active-high.
- EnableRequest  in  1  synchronous to Clock100MhzP; requests link power.
- Pair12Ok, Pair36Ok, Pair54Ok, Pair78Ok  in  1 each  asynchronous pair-check results.
- PowerEnable1236  out  1  enable for group A (12/36).
- PowerEnable5478  out  1  enable for group B (54/78).
- Fault  out  1  high for exactly one cycle per declared fault.
- FaultCount  out  3  saturating fault count.
- State  out  3  current state encoding.

## Operation
- Each PairxxOk input passes through a 2-flop synchronizer.
  - GroupA = sync12 & sync36.
  - GroupB = sync54 & sync78.
- One shared counter `cnt` (width fits max of all parameters). It clears on every state change.
- States:
  - IDLE: if EnableRequest & GroupA, go to DEBOUNCE.
  - DEBOUNCE: `cnt`++ while GroupA holds. If GroupA drops, go to IDLE. When `cnt` = DEBOUNCE_CYCLES-1 with GroupA high, go to POWER_A.
  - POWER_A: drives PowerEnable1236. `cnt` counts consecutive GroupB-good cycles and clears on a GroupB-bad cycle. At DEBOUNCE_CYCLES-1, go to POWER_AB. If GroupA is low for GLITCH_CYCLES consecutive cycles, go to FAULT. The glitch count uses a separate small counter `gcnt`, which clears on any good cycle.
  - POWER_AB: drives both enables. If (GroupA & GroupB) is low for GLITCH_CYCLES consecutive cycles, go to FAULT.
  - FAULT: one cycle. Enables are low, Fault = 1, FaultCount increments (saturating at 7). If the new count ≥ FAULT_LIMIT, go to LOCKOUT; otherwise go to RETRY_WAIT.
  - RETRY_WAIT: `cnt` counts to RETRY_CYCLES-1, then go to IDLE.
  - LOCKOUT: hold until EnableRequest = 0, then go to IDLE.
- EnableRequest = 0 in any state except FAULT: go to IDLE on the next edge, enables drop on that edge, and FaultCount clears to 0. From FAULT, the FAULT exit is taken first; the drop is then seen next cycle.
- State encoding: IDLE = 0, DEBOUNCE = 1, POWER_A = 2, POWER_AB = 3, FAULT = 4, RETRY_WAIT = 5, LOCKOUT = 6.

## Timing
- All outputs are registered and decoded from next-state, so they change on the same edge as State.
- Reset values:
  - State = IDLE.
  - PowerEnable1236 = 0, PowerEnable5478 = 0.
  - Fault = 0, FaultCount = 0.
  - Synchronizers = 0, `cnt` = 0, `gcnt` = 0.
- Reset mid-operation drops both enables on the reset edge.
- Enable latency: let edge k be the first edge sampling Pair12Ok & Pair36Ok high with EnableRequest high. Then:
  - DEBOUNCE is entered at edge k+2.
  - PowerEnable1236 rises at edge k+2+DEBOUNCE_CYCLES.
  - PowerEnable5478 rises DEBOUNCE_CYCLES edges after GroupB is continuously good in POWER_A, plus 2 synchronizer edges.
- Fault latency: GLITCH_CYCLES+2 edges from the first bad pin sample to the FAULT entry edge. Enables fall on that edge.
- Simultaneous events:
  - GroupA loss in POWER_A while GroupB qualifies: the fault path has priority over the POWER_AB transition.
  - EnableRequest drop beats every transition except the FAULT exit.

## Structure
- Package link_power_pkg holds:
  - State enum and its 3-bit encoding.
  - FaultCount width and saturation value (7).
  - Default timer constants.
- Sub-module sync2: a 2-flop synchronizer with synchronous active-high reset to 0, instantiated four times.
- Counters and FSM stay in link_power_sequencer.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, GLITCH_CYCLES = 2, RETRY_CYCLES = 8, FAULT_LIMIT = 2.
1. Nominal bring-up: all pairs good, EnableRequest high from edge 0.
   - PowerEnable1236 = 1 at edge 6.
   - PowerEnable5478 = 1 at edge 10.
   - State goes 0→1→2→3.
2. Debounce abort: Pair36Ok low for 1 cycle during DEBOUNCE.
   - Returns to IDLE, then re-qualifies.
   - PowerEnable1236 never rises before a full 4 good cycles.
3. Glitch tolerance: Pair12Ok low 1 cycle in POWER_AB.
   - No fault; enables stay 1.
4. Fault and retry: Pair54Ok held low 2+ cycles in POWER_AB.
   - Fault pulses 1 cycle, both enables 0, FaultCount = 1.
   - 8 cycles in RETRY_WAIT, then IDLE.
5. Lockout: a second fault gives FaultCount = 2 and State = 6 (LOCKOUT), enables stay 0.
   - EnableRequest low for 1 cycle gives State = 0 and FaultCount = 0.
6. Reset during POWER_AB: Reset high for 1 edge.
   - All outputs 0 and State = 0 on that edge.

Source files
------------

// File: rtl/link_power_pkg.sv
// Shared definitions for the link-power sequencer: state encoding, fault counter sizing, default timers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package link_power_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DEBOUNCE   = 3'd1,
    ST_POWER_A    = 3'd2,
    ST_POWER_AB   = 3'd3,
    ST_FAULT      = 3'd4,
    ST_RETRY_WAIT = 3'd5,
    ST_LOCKOUT    = 3'd6
  } lps_state_e;

  localparam int                     FAULT_CNT_W   = 3;
  localparam logic [FAULT_CNT_W-1:0] FAULT_CNT_MAX = 3'd7;

  // Defaults assume the 100 MHz clock.
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_GLITCH_CYCLES   = 16;
  localparam int DEF_RETRY_CYCLES    = 100000;
  localparam int DEF_FAULT_LIMIT     = 3;

  // Width of the shared timer: it never needs to hold more than (largest limit - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
// Latency: 2 clock edges from input sample to output.
// Backpressure: none (free-running level path).
// Ports: clk_i clock, rst_i sync active-high reset, d_i async input, q_o synchronized output.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/link_power_sequencer.sv
// Qualifies per-pair good flags and sequences power enables for pair groups 12/36 (A) and 54/78 (B),
// with glitch-based fault detection, saturating fault count, retry back-off and lockout.
// Latency: all outputs registered from next-state (change on the same edge as State); pair inputs add 2 sync edges.
// Backpressure: none; EnableRequest low returns to IDLE on the next edge (except from FAULT).
// Ports: Clock100MhzP clock; Reset sync active-high; EnableRequest power request;
//        Pair12Ok/Pair36Ok/Pair54Ok/Pair78Ok async pair status; PowerEnable1236/PowerEnable5478 group enables;
//        Fault one-cycle fault pulse; FaultCount saturating count; State current state encoding.
module link_power_sequencer
  import link_power_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GLITCH_CYCLES   = DEF_GLITCH_CYCLES,
  parameter int RETRY_CYCLES    = DEF_RETRY_CYCLES,
  parameter int FAULT_LIMIT     = DEF_FAULT_LIMIT
) (
  input  logic                   Clock100MhzP,
  input  logic                   Reset,
  input  logic                   EnableRequest,
  input  logic                   Pair12Ok,
  input  logic                   Pair36Ok,
  input  logic                   Pair54Ok,
  input  logic                   Pair78Ok,
  output logic                   PowerEnable1236,
  output logic                   PowerEnable5478,
  output logic                   Fault,
  output logic [FAULT_CNT_W-1:0] FaultCount,
  output logic [2:0]             State
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES, GLITCH_CYCLES, RETRY_CYCLES);
  localparam int GCNT_W = $clog2(GLITCH_CYCLES + 1);

  localparam logic [CNT_W-1:0]       DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
  localparam logic [GCNT_W-1:0]      GLITCH_MAX = GCNT_W'(GLITCH_CYCLES);
  localparam logic [FAULT_CNT_W-1:0] FAULT_LIM  = FAULT_CNT_W'(FAULT_LIMIT);

  logic sync12, sync36, sync54, sync78;
  logic grp_a, grp_b, grp_ab;

  lps_state_e state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GCNT_W-1:0]      gcnt_q, gcnt_d;
  logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   pe_a_q, pe_a_d;
  logic                   pe_b_q, pe_b_d;
  logic                   fault_q, fault_d;

  logic req_drop;
  logic glitch_hit;

  sync2 u_sync12 (.clk_i(Clock100MhzP), .rst_i(Reset), .d_i(Pair12Ok), .q_o(sync12));
  sync2 u_sync36 (.clk_i(Clock100MhzP), .rst_i(Reset), .d_i(Pair36Ok), .q_o(sync36));
  sync2 u_sync54 (.clk_i(Clock100MhzP), .rst_i(Reset), .d_i(Pair54Ok), .q_o(sync54));
  sync2 u_sync78 (.clk_i(Clock100MhzP), .rst_i(Reset), .d_i(Pair78Ok), .q_o(sync78));

  assign grp_a  = sync12 & sync36;
  assign grp_b  = sync54 & sync78;
  assign grp_ab = grp_a & grp_b;

  // FAULT always completes its exit first; a request drop is honoured the cycle after.
  assign req_drop = !EnableRequest && (state_q != ST_FAULT);

  // Fault is declared on the edge after GLITCH_CYCLES bad samples have been counted.
  assign glitch_hit = (gcnt_q == GLITCH_MAX);

  // State register
  always_ff @(posedge Clock100MhzP) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (req_drop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grp_a) state_d = ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (!grp_a)                 state_d = ST_IDLE;
          else if (cnt_q == DEB_LAST) state_d = ST_POWER_A;
        end
        ST_POWER_A: begin
          // Fault wins over promotion to POWER_AB on the same edge.
          if (glitch_hit)                       state_d = ST_FAULT;
          else if (grp_b && cnt_q == DEB_LAST)  state_d = ST_POWER_AB;
        end
        ST_POWER_AB: begin
          if (glitch_hit) state_d = ST_FAULT;
        end
        ST_FAULT: begin
          // fcnt_q already holds the incremented count here.
          state_d = (fcnt_q >= FAULT_LIM) ? ST_LOCKOUT : ST_RETRY_WAIT;
        end
        ST_RETRY_WAIT: begin
          if (cnt_q == RETRY_LAST) state_d = ST_IDLE;
        end
        ST_LOCKOUT: begin
          state_d = ST_LOCKOUT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shared timer and glitch counter; both restart on every state change.
  always_comb begin
    cnt_d  = '0;
    gcnt_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        ST_DEBOUNCE, ST_RETRY_WAIT: begin
          cnt_d = cnt_q + 1'b1;
        end
        ST_POWER_A: begin
          cnt_d  = grp_b ? cnt_q + 1'b1 : '0;
          gcnt_d = grp_a ? '0 : (glitch_hit ? gcnt_q : gcnt_q + 1'b1);
        end
        ST_POWER_AB: begin
          gcnt_d = grp_ab ? '0 : (glitch_hit ? gcnt_q : gcnt_q + 1'b1);
        end
        default: begin
          cnt_d  = '0;
          gcnt_d = '0;
        end
      endcase
    end
  end

  // Output decode from next-state
  always_comb begin
    pe_a_d  = (state_d == ST_POWER_A) || (state_d == ST_POWER_AB);
    pe_b_d  = (state_d == ST_POWER_AB);
    fault_d = (state_d == ST_FAULT);
    fcnt_d  = fcnt_q;
    if (req_drop) begin
      fcnt_d = '0;
    end else if (state_d == ST_FAULT && state_q != ST_FAULT && fcnt_q != FAULT_CNT_MAX) begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock100MhzP) begin
    if (Reset) begin
      cnt_q   <= '0;
      gcnt_q  <= '0;
      fcnt_q  <= '0;
      pe_a_q  <= 1'b0;
      pe_b_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      fcnt_q  <= fcnt_d;
      pe_a_q  <= pe_a_d;
      pe_b_q  <= pe_b_d;
      fault_q <= fault_d;
    end
  end

  assign PowerEnable1236 = pe_a_q;
  assign PowerEnable5478 = pe_b_q;
  assign Fault           = fault_q;
  assign FaultCount      = fcnt_q;
  assign State           = state_q;

endmodule

// File: tb/tb_link_power_sequencer.sv
// Bench for link_power_sequencer with small timers (debounce 4, glitch 2, retry 8, fault limit 2).
// Stimulus queues the expected output snapshot and edge number of every output change; the monitor
// pops one entry whenever any output changes and compares all fields.
module tb_link_power_sequencer;

  logic       clk = 1'b0;
  logic       Reset;
  logic       EnableRequest;
  logic       Pair12Ok, Pair36Ok, Pair54Ok, Pair78Ok;
  logic       PowerEnable1236, PowerEnable5478, Fault;
  logic [2:0] FaultCount;
  logic [2:0] State;

  always #5 clk = ~clk;

  link_power_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .GLITCH_CYCLES  (2),
    .RETRY_CYCLES   (8),
    .FAULT_LIMIT    (2)
  ) dut (
    .Clock100MhzP   (clk),
    .Reset          (Reset),
    .EnableRequest  (EnableRequest),
    .Pair12Ok       (Pair12Ok),
    .Pair36Ok       (Pair36Ok),
    .Pair54Ok       (Pair54Ok),
    .Pair78Ok       (Pair78Ok),
    .PowerEnable1236(PowerEnable1236),
    .PowerEnable5478(PowerEnable5478),
    .Fault          (Fault),
    .FaultCount     (FaultCount),
    .State          (State)
  );

  typedef struct {
    int         edge_no;
    logic [2:0] st;
    logic       pa;
    logic       pb;
    logic       f;
    logic [2:0] fc;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  always @(posedge clk) edge_n++;

  function automatic void push(input int e, input logic [2:0] st, input logic pa,
                               input logic pb, input logic f, input logic [2:0] fc);
    exp_t x;
    x.edge_no = e;
    x.st      = st;
    x.pa      = pa;
    x.pb      = pb;
    x.f       = f;
    x.fc      = fc;
    q.push_back(x);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (at edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Monitor: any change of any output is one DUT event.
  logic [8:0] prev_out;
  logic [8:0] cur_out;
  logic       first = 1'b1;

  always @(negedge clk) begin
    exp_t x;
    cur_out = {State, PowerEnable1236, PowerEnable5478, Fault, FaultCount};
    if (first || cur_out != prev_out) begin
      first = 1'b0;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: got state=%0d pe=%b%b fault=%b fc=%0d, expected no change (at edge %0d)",
                 State, PowerEnable1236, PowerEnable5478, Fault, FaultCount, edge_n);
      end else begin
        x = q.pop_front();
        chk("event_edge", edge_n, x.edge_no);
        chk("state", int'(State), int'(x.st));
        chk("pe1236", int'(PowerEnable1236), int'(x.pa));
        chk("pe5478", int'(PowerEnable5478), int'(x.pb));
        chk("fault", int'(Fault), int'(x.f));
        chk("fault_count", int'(FaultCount), int'(x.fc));
      end
      prev_out = cur_out;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e;
    Reset         = 1'b1;
    EnableRequest = 1'b0;
    Pair12Ok      = 1'b0;
    Pair36Ok      = 1'b0;
    Pair54Ok      = 1'b0;
    Pair78Ok      = 1'b0;
    // Reset state, observed after the first edge.
    push(1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(3);

    // 1. Nominal bring-up: k = e+1 is the first sampling edge.
    Reset = 1'b0;
    Pair12Ok = 1'b1; Pair36Ok = 1'b1; Pair54Ok = 1'b1; Pair78Ok = 1'b1;
    EnableRequest = 1'b1;
    e = edge_n;
    push(e + 3,  3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
    push(e + 7,  3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    push(e + 11, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0);
    step(13);

    // 2. Request drop to IDLE, then debounce abort from a one-cycle Pair36 dropout.
    e = edge_n;
    EnableRequest = 1'b0;
    push(e + 1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1);
    EnableRequest = 1'b1;
    push(e + 2, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
    step(2);
    Pair36Ok = 1'b0;
    step(1);
    Pair36Ok = 1'b1;
    push(e + 6,  3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    push(e + 7,  3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
    push(e + 11, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    push(e + 15, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0);
    step(13);

    // 3. One-cycle Pair12 glitch in POWER_AB: no output change expected.
    Pair12Ok = 1'b0;
    step(1);
    Pair12Ok = 1'b1;
    step(10);

    // 4. Pair54 held low: fault, retry back-off, re-qualify.
    e = edge_n;
    Pair54Ok = 1'b0;
    push(e + 5,  3'd4, 1'b0, 1'b0, 1'b1, 3'd1);
    push(e + 6,  3'd5, 1'b0, 1'b0, 1'b0, 3'd1);
    push(e + 14, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    push(e + 15, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    push(e + 19, 3'd2, 1'b1, 1'b0, 1'b0, 3'd1);
    step(20);
    Pair54Ok = 1'b1;
    push(e + 26, 3'd3, 1'b1, 1'b1, 1'b0, 3'd1);
    step(10);

    // 5. Second fault reaches the limit: lockout until the request drops.
    e = edge_n;
    Pair54Ok = 1'b0;
    push(e + 5, 3'd4, 1'b0, 1'b0, 1'b1, 3'd2);
    push(e + 6, 3'd6, 1'b0, 1'b0, 1'b0, 3'd2);
    step(7);
    Pair54Ok = 1'b1;
    step(6);
    e = edge_n;
    EnableRequest = 1'b0;
    push(e + 1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1);
    EnableRequest = 1'b1;
    push(e + 2,  3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
    push(e + 6,  3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    push(e + 10, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0);
    step(12);

    // 6. Reset for one edge in POWER_AB; synchronizers restart from 0.
    e = edge_n;
    Reset = 1'b1;
    push(e + 1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1);
    Reset = 1'b0;
    push(e + 4,  3'd1, 1'b0, 1'b0, 1'b0, 3'd0);
    push(e + 8,  3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    push(e + 12, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0);
    step(14);

    step(2);
    chk("pending_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
